mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Pipeline stage directly downstream of the MEMORY stage: MEM/WB pipeline latch plus write-back logic.
- Registers the MEM results each enabled cycle and extracts and extends load data by access size and byte offset.
- Selects the register-file write value: memory, ALU or return address.
- Drives the register-file write port and the WB forwarding path; tracks HALT retirement for the debug unit.

Parameters:
NB_DATA, 32, data/ALU width
NB_PC, 32, program-counter width
NB_REG, 5, register index width

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  asynchronous reset, active-high
i_enable  in  1  pipeline step enable (debug unit); 0 = hold
i_flush  in  1  load a bubble into the latch
i_MEM_valid  in  1  MEM slot holds a real instruction
i_MEM_mem_data  in  NB_DATA  raw word read at word address alu_result[31:2]
i_MEM_alu_result  in  NB_DATA  ALU result / effective address
i_MEM_selected_reg  in  NB_REG  destination register
i_MEM_reg_write  in  1  instruction writes a register
i_MEM_mem_to_reg  in  1  write-back source is memory
i_MEM_last_register_ctrl  in  1  write-back source is return address (JAL/JALR)
i_MEM_pc  in  NB_PC  PC+4 of the instruction
i_MEM_byte_enable  in  1  byte load
i_MEM_halfword_enable  in  1  halfword load
i_MEM_word_enable  in  1  word load
i_MEM_unsigned  in  1  zero-extend (LBU/LHU)
i_MEM_halt  in  1  instruction is HALT
o_WB_write_data  out  NB_DATA  register-file write data
o_WB_selected_reg  out  NB_REG  register-file write index
o_WB_reg_write  out  1  register-file write strobe
o_WB_valid  out  1  WB slot holds a real instruction
o_WB_halt  out  1  HALT has retired; sticky

Behaviour:
Reset:
- All latch fields clear to 0; FSM goes to RUN.
- All outputs are 0.

Latch update (rising edge):
- i_reset has top priority, then HALTED freeze, then i_flush, then i_enable.
- i_flush=1 (regardless of i_enable): valid, reg_write and halt clear to 0; other fields clear to 0.
- i_enable=1, no flush: all i_MEM_* fields are captured.
- i_enable=0, no flush: latch holds.

Latency:
- One cycle from MEM inputs to WB outputs.
- o_WB_write_data is combinational from latched fields only.

Load extraction (little-endian; off = latched alu_result[1:0]):
- byte: lane off; sign- or zero-extend from bit 7.
- halfword: lane off[1] (off[0] ignored; no trap); sign- or zero-extend from bit 15.
- word, or no size flag set: full word.
- More than one size flag set: priority word > halfword > byte.

Write-back source select:
- last_register_ctrl=1: latched pc + 4 (= instruction PC + 8), modulo 2^NB_PC. Takes priority over mem_to_reg.
- else mem_to_reg=1: extracted load data.
- else: latched alu_result.

Register-file write strobe:
- o_WB_reg_write = latched reg_write AND valid AND selected_reg != 0. No write ever targets $0.

FSM:
- RUN -> HALTED on any edge that latches valid=1 and halt=1.
- In HALTED: o_WB_halt=1; latch frozen (enable and flush ignored); o_WB_reg_write=0 from the cycle after entry.
- The HALT instruction itself performs no register write.
- HALTED -> RUN only via i_reset.
- Reset asserted mid-operation: latch and FSM clear asynchronously; no write strobe is emitted in that cycle.

Optional Feature:
WB_RETIRE_CNT_EN
- Defined: adds output o_WB_retired (32 bits), reset to 0.
- Increments by 1 on each edge where a valid, non-halt instruction is latched; wraps 0xFFFFFFFF -> 0.
- Frozen in HALTED.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package mips_pkg: width constants (NB_DATA, NB_PC, NB_REG), FSM state encoding (ST_RUN, ST_HALTED), access-size encoding.
- One sub-module, wb_load_extract: combinational lane select and sign/zero extension (inputs: word, offset, size flags, unsigned; output: extended data).

Test Plan:
- mem_data=0x81807F01, mem_to_reg=1, byte, signed, alu=0x11, reg=5, enable -> next cycle write_data=0x0000007F, selected_reg=5, reg_write=1.
- Same word, byte signed, alu=0x13 -> 0xFFFFFF81; halfword, alu=0x12: signed -> 0xFFFF8180, unsigned -> 0x00008180.
- last_register_ctrl=1 with mem_to_reg=1, pc=0x40 -> write_data=0x44; alu=0x1234, both selects 0 -> 0x1234; reg=0 with reg_write=1 -> reg_write=0.
- i_enable=0 for 3 cycles with changing inputs -> outputs unchanged. i_flush=1 with i_enable=0 -> valid=0, reg_write=0 next cycle.
- Valid HALT latched -> o_WB_halt=1, stays 1 with later enable/flush activity; i_reset pulse mid-cycle -> all outputs 0 immediately, FSM back in RUN.
- WB_RETIRE_CNT_EN defined: 4 valid instructions, 1 bubble, 1 HALT -> o_WB_retired=4 and stays 4.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and encodings for the MEM/WB slice of the pipeline.
package mips_pkg;

  localparam int unsigned NB_DATA   = 32;
  localparam int unsigned NB_PC     = 32;
  localparam int unsigned NB_REG    = 5;
  localparam int unsigned NB_RETIRE = 32;

  // Write-back stage run state
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } wb_state_t;

  // Load access size after flag priority resolution
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Word wins over halfword over byte; no flag at all means a full word
  function automatic access_size_t decode_size(input logic word_en,
                                               input logic half_en,
                                               input logic byte_en);
    access_size_t size;
    size = SZ_WORD;
    if (word_en) begin
      size = SZ_WORD;
    end else if (half_en) begin
      size = SZ_HALF;
    end else if (byte_en) begin
      size = SZ_BYTE;
    end
    return size;
  endfunction

endpackage

// File: rtl/wb_load_extract.sv
// Little-endian lane select and sign/zero extension of a loaded word.
module wb_load_extract #(
  parameter int unsigned NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] word_in,
  input  logic [1:0]         offset,
  input  logic               byte_en,
  input  logic               half_en,
  input  logic               word_en,
  input  logic               is_unsigned,
  output logic [NB_DATA-1:0] data_out
);
  import mips_pkg::*;

  access_size_t size;
  logic [7:0]   byte_lane;
  logic [15:0]  half_lane;

  // Pick the addressed lane, then extend it to the full data width
  always_comb begin
    size      = decode_size(word_en, half_en, byte_en);
    byte_lane = 8'(word_in >> {offset, 3'b000});
    // Halfword alignment is not enforced: the low offset bit is ignored
    half_lane = 16'(word_in >> {offset[1], 4'b0000});
    data_out  = word_in;
    case (size)
      SZ_BYTE: data_out = is_unsigned ? NB_DATA'(byte_lane)
                                      : {{(NB_DATA-8){byte_lane[7]}}, byte_lane};
      SZ_HALF: data_out = is_unsigned ? NB_DATA'(half_lane)
                                      : {{(NB_DATA-16){half_lane[15]}}, half_lane};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline latch, write-back source select and HALT retirement tracking.
// Optional feature macro: WB_RETIRE_CNT_EN adds the o_WB_retired counter.
module mem_wb_stage #(
  parameter int unsigned NB_DATA = mips_pkg::NB_DATA,
  parameter int unsigned NB_PC   = mips_pkg::NB_PC,
  parameter int unsigned NB_REG  = mips_pkg::NB_REG
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_flush,
  input  logic               i_MEM_valid,
  input  logic [NB_DATA-1:0] i_MEM_mem_data,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_last_register_ctrl,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  input  logic               i_MEM_byte_enable,
  input  logic               i_MEM_halfword_enable,
  input  logic               i_MEM_word_enable,
  input  logic               i_MEM_unsigned,
  input  logic               i_MEM_halt,
  output logic [NB_DATA-1:0] o_WB_write_data,
  output logic [NB_REG-1:0]  o_WB_selected_reg,
  output logic               o_WB_reg_write,
  output logic               o_WB_valid,
  output logic               o_WB_halt
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]        o_WB_retired
`endif
);
  import mips_pkg::*;

  wb_state_t state, state_next;
  logic      latch_capture;
  logic      latch_bubble;
  logic      retire_inc;

  logic               lat_valid;
  logic [NB_DATA-1:0] lat_mem_data;
  logic [NB_DATA-1:0] lat_alu_result;
  logic [NB_REG-1:0]  lat_selected_reg;
  logic               lat_reg_write;
  logic               lat_mem_to_reg;
  logic               lat_last_register_ctrl;
  logic [NB_PC-1:0]   lat_pc;
  logic               lat_byte_enable;
  logic               lat_halfword_enable;
  logic               lat_word_enable;
  logic               lat_unsigned;
  logic               lat_halt;
  logic [NB_DATA-1:0] load_data;

  // FSM state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and latch control; HALTED freezes everything until reset
  always_comb begin
    state_next    = state;
    latch_capture = 1'b0;
    latch_bubble  = 1'b0;
    retire_inc    = 1'b0;
    case (state)
      ST_RUN: begin
        if (i_flush) begin
          latch_bubble = 1'b1;
        end else if (i_enable) begin
          latch_capture = 1'b1;
          if (i_MEM_valid && i_MEM_halt) begin
            state_next = ST_HALTED;
          end
          if (i_MEM_valid && !i_MEM_halt) begin
            retire_inc = 1'b1;
          end
        end
      end
      default: state_next = ST_HALTED;
    endcase
  end

  // MEM/WB pipeline latch
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset || latch_bubble) begin
      lat_valid              <= 1'b0;
      lat_mem_data           <= '0;
      lat_alu_result         <= '0;
      lat_selected_reg       <= '0;
      lat_reg_write          <= 1'b0;
      lat_mem_to_reg         <= 1'b0;
      lat_last_register_ctrl <= 1'b0;
      lat_pc                 <= '0;
      lat_byte_enable        <= 1'b0;
      lat_halfword_enable    <= 1'b0;
      lat_word_enable        <= 1'b0;
      lat_unsigned           <= 1'b0;
      lat_halt               <= 1'b0;
    end else if (latch_capture) begin
      lat_valid              <= i_MEM_valid;
      lat_mem_data           <= i_MEM_mem_data;
      lat_alu_result         <= i_MEM_alu_result;
      lat_selected_reg       <= i_MEM_selected_reg;
      lat_reg_write          <= i_MEM_reg_write;
      lat_mem_to_reg         <= i_MEM_mem_to_reg;
      lat_last_register_ctrl <= i_MEM_last_register_ctrl;
      lat_pc                 <= i_MEM_pc;
      lat_byte_enable        <= i_MEM_byte_enable;
      lat_halfword_enable    <= i_MEM_halfword_enable;
      lat_word_enable        <= i_MEM_word_enable;
      lat_unsigned           <= i_MEM_unsigned;
      lat_halt               <= i_MEM_halt;
    end
  end

  wb_load_extract #(
    .NB_DATA (NB_DATA)
  ) u_load_extract (
    .word_in     (lat_mem_data),
    .offset      (lat_alu_result[1:0]),
    .byte_en     (lat_byte_enable),
    .half_en     (lat_halfword_enable),
    .word_en     (lat_word_enable),
    .is_unsigned (lat_unsigned),
    .data_out    (load_data)
  );

  // Write-back value and register-file strobe, derived from latched fields only
  always_comb begin
    o_WB_write_data = lat_alu_result;
    if (lat_last_register_ctrl) begin
      // Latched pc is already PC+4, so the link value is one more word on
      o_WB_write_data = NB_DATA'(lat_pc + NB_PC'(4));
    end else if (lat_mem_to_reg) begin
      o_WB_write_data = load_data;
    end
    o_WB_selected_reg = lat_selected_reg;
    o_WB_valid        = lat_valid;
    o_WB_halt         = (state == ST_HALTED);
    o_WB_reg_write    = lat_reg_write && lat_valid && !lat_halt
                        && (lat_selected_reg != '0) && (state == ST_RUN);
  end

`ifdef WB_RETIRE_CNT_EN
  logic [NB_RETIRE-1:0] retired_cnt;

  // Count retired non-HALT instructions, wrapping naturally
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      retired_cnt <= '0;
    end else if (retire_inc) begin
      retired_cnt <= retired_cnt + NB_RETIRE'(1);
    end
  end

  assign o_WB_retired = 32'(retired_cnt);
`endif

endmodule
